ntt_bram_rd_ctrl: RTL and testbench
===================================

Name: ntt_bram_rd_ctrl

Overview:
Read-side sequencer for the 8-bank, 8-butterfly NTT datapath (256 coefficients, 12-bit, bank = i mod 8, row = i div 8, 32 rows/bank, dual-port A/B).
- On start, walks all 7 stages of a forward NTT (len 128→2) or inverse NTT (len 2→128).
- Per cycle it issues one shared row address on port A and one on port B of all 8 banks.
- Publishes the current len to the downstream butterfly-input selector, which consumes the 16 returned words and routes them to the 8 BUs.

Parameters:
RD_LAT, 1, BRAM read latency in cycles; data_vld_o lags rd_en_o by exactly this.
STAGE_GAP, 4, idle cycles between stages for BU pipeline/writeback drain; must be ≥ RD_LAT.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
start_i  in  1  begin transform; sampled only in IDLE
mode_i  in  1  0 = NTT, 1 = iNTT; sampled with start_i
busy_o  out  1  high from first READ cycle through last GAP cycle
done_o  out  1  one-cycle pulse at transform end
len_o  out  8  current stage len (to selector len_i)
stage_o  out  3  stage index 0..6
rd_en_o  out  1  read enable, all 16 ports
addr_a_o  out  5  row address, port A, all banks
addr_b_o  out  5  row address, port B, all banks
data_vld_o  out  1  rd_en_o delayed RD_LAT cycles; BRAM data valid

Behaviour:
- Clock and reset: one clock, clk_i; rst_i is asynchronous, active-high.
- Reset: state IDLE; all outputs 0, including len_o; internal counters 0. Reset mid-transform aborts immediately; the data_vld_o delay line is cleared.
- FSM states: IDLE, READ, GAP.
- IDLE→READ: start_i=1 at edge. Latch mode, stage=0, k=0.
- READ: lasts 16 cycles, k = 0..15. rd_en_o=1. After k=15 go to GAP.
- GAP: lasts STAGE_GAP cycles, rd_en_o=0. Then:
  - stage<6: stage+1, k=0, go to READ.
  - stage=6: go to IDLE, assert done_o for that one cycle.
- All outputs are registered. In the first READ cycle, rd_en_o, addresses, len_o and stage_o are all valid together.
- len_o: NTT = 128>>stage; iNTT = 2<<stage. Holds through READ and GAP and updates on entry to the next READ. Because STAGE_GAP ≥ RD_LAT, the last data_vld_o of a stage always sees the matching len_o. On return to IDLE, len_o and stage_o hold their last values.
- Address generation, with L = len/8:
  - len ≥ 8: addr_a = ((k & ~(L−1)) << 1) | (k & (L−1)); addr_b = addr_a + L. Pair (j, j+len) lies in the same bank, rows addr_a and addr_b.
  - len ∈ {4, 2}: addr_a = 2k; addr_b = 2k+1. The pair spans banks within rows; the selector resolves it.
- Address arithmetic is 5-bit. No overflow is possible by construction; addr_b ≤ 31.
- start_i while busy is ignored; mode_i changes mid-transform have no effect.
- start_i in the same cycle done_o is high: ignored, because the FSM is entering IDLE. Start is accepted from the following cycle.
- busy_o=1 in READ and GAP; 0 in IDLE.
- Total transform: 7·(16+STAGE_GAP) cycles from first READ to done_o.

Test Plan:
- Reset/idle: hold rst_i, then release with start_i=0 for 10 cycles → all outputs 0, busy_o=0.
- NTT timing (defaults): start_i sampled at edge 0, mode=0 → rd_en_o high cycles 1–16, 21–36, …, 121–136; data_vld_o high cycles 2–17, …; busy_o high 1–140; done_o pulse at cycle 141 only; len_o = 128,64,32,16,8,4,2 per stage.
- Addresses, NTT:
  - len=128: k=0→(0,16), k=15→(15,31).
  - len=32: k=5→(9,13).
  - len=8: k=1→(2,3), k=15→(30,31).
  - len=2: k=7→(14,15).
- iNTT: mode=1 → len_o sequence 2,4,8,16,32,64,128; stage 6 k=3→(3,19); done_o after 140 busy cycles.
- Abuse: start_i held high throughout, mode_i toggled mid-run → exactly one transform, no restart before done. Restart accepted on the cycle after done_o.
- Async reset pulse mid-stage 3, k=7 → outputs 0 immediately without a clock edge, no data_vld_o afterward. A new start gives the normal stage-0 sequence.

Source files
------------

// File: rtl/ntt_bram_rd_ctrl_if.sv
// Control, status and shared row-address bus between the NTT read sequencer and its neighbours.
// The slave side is the sequencer; the master side is the controller/selector that drives start and consumes reads.
interface ntt_bram_rd_ctrl_if;
   logic       start_i;
   logic       mode_i;
   logic       busy_o;
   logic       done_o;
   logic [7:0] len_o;
   logic [2:0] stage_o;
   logic       rd_en_o;
   logic [4:0] addr_a_o;
   logic [4:0] addr_b_o;
   logic       data_vld_o;

   modport slave (
      input  start_i, mode_i,
      output busy_o, done_o, len_o, stage_o, rd_en_o, addr_a_o, addr_b_o, data_vld_o
   );

   modport master (
      output start_i, mode_i,
      input  busy_o, done_o, len_o, stage_o, rd_en_o, addr_a_o, addr_b_o, data_vld_o
   );
endinterface

// File: rtl/ntt_bram_rd_ctrl.sv
// Walks the 7 NTT/iNTT stages, issuing 16 dual-port row reads per stage then STAGE_GAP idle cycles.
// All outputs registered (valid the cycle after start is sampled); no backpressure, data_vld_o lags rd_en_o by RD_LAT.
module ntt_bram_rd_ctrl #(
   parameter int RD_LAT    = 1,
   parameter int STAGE_GAP = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   ntt_bram_rd_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, READ, GAP} state_t;

   localparam int CNT_W = (STAGE_GAP > 16) ? $clog2(STAGE_GAP) : 4;
   localparam logic [CNT_W-1:0] K_LAST   = CNT_W'(15);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        stage_q, stage_d;
   logic              mode_q, mode_d;
   logic              done_q, done_d;
   logic              busy_q, rd_en_q;
   logic [7:0]        len_q, len_d;
   logic [4:0]        addr_a_q, addr_a_d, addr_b_q, addr_b_d;
   logic [4:0]        l_rows, mask, k5;
   logic [RD_LAT-1:0] vld_sr_q;

   function automatic logic [7:0] stage_len(input logic [2:0] s, input logic m);
      return m ? (8'd2 << s) : (8'd128 >> s);
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stage_d = stage_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // done_q marks the cycle we just returned to IDLE; a start there is dropped
            if (bus.start_i && !done_q) begin
               state_d = READ;
               cnt_d   = '0;
               stage_d = '0;
               mode_d  = bus.mode_i;
            end
         end
         READ: begin
            if (cnt_q == K_LAST) begin
               state_d = GAP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = '0;
               if (stage_q == 3'd6) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = READ;
                  stage_d = stage_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output values are derived from next-state so they register alongside the state change.
   always_comb begin
      len_d    = len_q;
      addr_a_d = '0;
      addr_b_d = '0;
      l_rows   = '0;
      mask     = '0;
      k5       = {1'b0, cnt_d[3:0]};
      if (state_d == READ) begin
         len_d = stage_len(stage_d, mode_d);
         if (len_d >= 8'd8) begin
            l_rows   = len_d[7:3];
            mask     = l_rows - 5'd1;
            addr_a_d = ((k5 & ~mask) << 1) | (k5 & mask);
            addr_b_d = addr_a_d + l_rows;
         end else begin
            addr_a_d = {cnt_d[3:0], 1'b0};
            addr_b_d = {cnt_d[3:0], 1'b1};
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         stage_q  <= '0;
         mode_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         rd_en_q  <= 1'b0;
         len_q    <= '0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         vld_sr_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         stage_q  <= stage_d;
         mode_q   <= mode_d;
         done_q   <= done_d;
         busy_q   <= (state_d != IDLE);
         rd_en_q  <= (state_d == READ);
         len_q    <= len_d;
         addr_a_q <= addr_a_d;
         addr_b_q <= addr_b_d;
         vld_sr_q[0] <= rd_en_q;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_sr_q[i] <= vld_sr_q[i-1];
         end
      end
   end

   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.len_o      = len_q;
   assign bus.stage_o    = stage_q;
   assign bus.rd_en_o    = rd_en_q;
   assign bus.addr_a_o   = addr_a_q;
   assign bus.addr_b_o   = addr_b_q;
   assign bus.data_vld_o = vld_sr_q[RD_LAT-1];

endmodule

// File: tb/tb_ntt_bram_rd_ctrl.sv
// Directed bench for ntt_bram_rd_ctrl: per-cycle timing, table of len/stage/address points, abuse and async-reset sequences.
module tb_ntt_bram_rd_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ntt_bram_rd_ctrl_if bus();

   ntt_bram_rd_ctrl #(.RD_LAT(1), .STAGE_GAP(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic       rd_en;
      logic       vld;
      logic       busy;
      logic       done;
      logic [7:0] len;
      logic [2:0] stg;
      logic [4:0] a;
      logic [4:0] b;
   } cap_t;

   typedef struct {
      logic       m;
      int         cyc;
      logic [7:0] len;
      logic [2:0] stg;
      bit         chk_addr;
      logic [4:0] a;
      logic [4:0] b;
   } vec_t;

   cap_t trace [0:159];
   vec_t vecs  [22];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic cap_t sample();
      cap_t s;
      s.rd_en = bus.rd_en_o;
      s.vld   = bus.data_vld_o;
      s.busy  = bus.busy_o;
      s.done  = bus.done_o;
      s.len   = bus.len_o;
      s.stg   = bus.stage_o;
      s.a     = bus.addr_a_o;
      s.b     = bus.addr_b_o;
      return s;
   endfunction

   // Cycle c is the clock period following edge c-1; edge 0 samples start_i.
   task automatic run(input logic m, input bit hold, input bit toggle, input int ncyc);
      @(negedge clk);
      bus.start_i = 1'b1;
      bus.mode_i  = m;
      @(posedge clk);
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         trace[c] = sample();
         if (!hold)  bus.start_i = 1'b0;
         if (toggle) bus.mode_i  = ~bus.mode_i;
      end
      bus.start_i = 1'b0;
   endtask

   function automatic bit in_read(input int c);
      for (int s = 0; s < 7; s++)
         if (c >= 1 + 20*s && c <= 16 + 20*s) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_timing(input int last);
      for (int c = 1; c <= last; c++) begin
         logic [3:0] exp;
         exp = {in_read(c), in_read(c-1), (c >= 1 && c <= 140), (c == 141)};
         check($sformatf("timing{rd,vld,busy,done} c%0d", c),
               int'({trace[c].rd_en, trace[c].vld, trace[c].busy, trace[c].done}), int'(exp));
      end
   endtask

   task automatic check_table(input logic m, input int ncyc);
      for (int i = 0; i < 22; i++) begin
         if (vecs[i].m == m && vecs[i].cyc <= ncyc) begin
            check($sformatf("len m%0d c%0d", m, vecs[i].cyc), int'(trace[vecs[i].cyc].len), int'(vecs[i].len));
            check($sformatf("stage m%0d c%0d", m, vecs[i].cyc), int'(trace[vecs[i].cyc].stg), int'(vecs[i].stg));
            if (vecs[i].chk_addr) begin
               check($sformatf("addr_a m%0d c%0d", m, vecs[i].cyc), int'(trace[vecs[i].cyc].a), int'(vecs[i].a));
               check($sformatf("addr_b m%0d c%0d", m, vecs[i].cyc), int'(trace[vecs[i].cyc].b), int'(vecs[i].b));
            end
         end
      end
   endtask

   initial begin
      vecs[0]  = '{1'b0,   1, 8'd128, 3'd0, 1'b1, 5'd0,  5'd16};
      vecs[1]  = '{1'b0,  16, 8'd128, 3'd0, 1'b1, 5'd15, 5'd31};
      vecs[2]  = '{1'b0,  20, 8'd128, 3'd0, 1'b0, 5'd0,  5'd0};
      vecs[3]  = '{1'b0,  21, 8'd64,  3'd1, 1'b1, 5'd0,  5'd8};
      vecs[4]  = '{1'b0,  46, 8'd32,  3'd2, 1'b1, 5'd9,  5'd13};
      vecs[5]  = '{1'b0,  61, 8'd16,  3'd3, 1'b1, 5'd0,  5'd2};
      vecs[6]  = '{1'b0,  62, 8'd16,  3'd3, 1'b1, 5'd1,  5'd3};
      vecs[7]  = '{1'b0,  63, 8'd16,  3'd3, 1'b1, 5'd4,  5'd6};
      vecs[8]  = '{1'b0,  82, 8'd8,   3'd4, 1'b1, 5'd2,  5'd3};
      vecs[9]  = '{1'b0,  96, 8'd8,   3'd4, 1'b1, 5'd30, 5'd31};
      vecs[10] = '{1'b0, 104, 8'd4,   3'd5, 1'b1, 5'd6,  5'd7};
      vecs[11] = '{1'b0, 128, 8'd2,   3'd6, 1'b1, 5'd14, 5'd15};
      vecs[12] = '{1'b0, 145, 8'd2,   3'd6, 1'b0, 5'd0,  5'd0};
      vecs[13] = '{1'b1,   1, 8'd2,   3'd0, 1'b1, 5'd0,  5'd1};
      vecs[14] = '{1'b1,  21, 8'd4,   3'd1, 1'b1, 5'd0,  5'd1};
      vecs[15] = '{1'b1,  41, 8'd8,   3'd2, 1'b1, 5'd0,  5'd1};
      vecs[16] = '{1'b1,  61, 8'd16,  3'd3, 1'b1, 5'd0,  5'd2};
      vecs[17] = '{1'b1,  81, 8'd32,  3'd4, 1'b1, 5'd0,  5'd4};
      vecs[18] = '{1'b1, 101, 8'd64,  3'd5, 1'b1, 5'd0,  5'd8};
      vecs[19] = '{1'b1, 124, 8'd128, 3'd6, 1'b1, 5'd3,  5'd19};
      vecs[20] = '{1'b1, 137, 8'd128, 3'd6, 1'b0, 5'd0,  5'd0};
      vecs[21] = '{1'b1, 145, 8'd128, 3'd6, 1'b0, 5'd0,  5'd0};

      bus.start_i = 1'b0;
      bus.mode_i  = 1'b0;

      // Reset and idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("outputs in reset", int'(sample()), 0);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("idle outputs c%0d", c), int'(sample()), 0);
      end

      // Forward NTT
      run(1'b0, 1'b0, 1'b0, 145);
      check_timing(145);
      check_table(1'b0, 145);

      // Inverse NTT
      run(1'b1, 1'b0, 1'b0, 145);
      check_timing(145);
      check_table(1'b1, 145);

      // start held high, mode toggling every cycle
      run(1'b0, 1'b1, 1'b1, 144);
      check_timing(141);
      check_table(1'b0, 144);
      check("abuse busy c142", int'(trace[142].busy), 0);
      check("abuse rd_en c142", int'(trace[142].rd_en), 0);
      check("abuse busy c143", int'(trace[143].busy), 1);
      check("abuse rd_en c143", int'(trace[143].rd_en), 1);
      check("abuse stage c143", int'(trace[143].stg), 0);
      check("abuse len c143", int'(trace[143].len), 128);

      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Async reset in stage 3, k=7
      run(1'b0, 1'b0, 1'b0, 68);
      check("pre-reset stage", int'(trace[68].stg), 3);
      check("pre-reset addr_a", int'(trace[68].a), 13);
      check("pre-reset addr_b", int'(trace[68].b), 15);
      check("pre-reset data_vld", int'(trace[68].vld), 1);
      #1 rst = 1'b1;
      #1 check("outputs right after async reset", int'(sample()), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("post-reset {rd,vld,busy} c%0d", c),
               int'({bus.rd_en_o, bus.data_vld_o, bus.busy_o}), 0);
      end

      run(1'b0, 1'b0, 1'b0, 25);
      check_timing(25);
      check_table(1'b0, 25);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
